// File: rtl/freq_div_pkg.sv
// Shared constants for the programmable frequency divider and its divisor selector.
package freq_div_pkg;

  localparam int DIV_W = 32;

  // Smallest divisor ever loaded; requests below it are clamped up.
  localparam logic [DIV_W-1:0] MIN_DIV = 2;

  // Named divisor choices, also consumed by the selector.
  localparam logic [DIV_W-1:0] DIV_SEL0 = 32'd512000;
  localparam logic [DIV_W-1:0] DIV_SEL1 = 32'd1024000;
  localparam logic [DIV_W-1:0] DIV_SEL2 = 32'd2048000;
  localparam logic [DIV_W-1:0] DIV_SEL3 = 32'd4096000;

endpackage

// File: rtl/freq_div.sv
// Programmable frequency divider: divided square wave plus a one-cycle tick at
// the start of every output period. The divisor is only sampled at period
// boundaries so a selection change never creates a runt or stretched pulse.
module freq_div
  import freq_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_n,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] divQ;
  logic [DIV_W-1:0] cntInc;
  logic             wrap;

  // Divisors 0 and 1 are meaningless for a square wave; force them to MIN_DIV.
  function automatic logic [DIV_W-1:0] clampDiv(input logic [DIV_W-1:0] d);
    return (d >= MIN_DIV) ? d : MIN_DIV;
  endfunction

  // Period boundary detect; divQ never drops below 1 so divQ - 1 cannot underflow.
  always_comb begin
    cntInc = cnt + ONE;
    wrap   = clr | (en & (cnt == (divQ - ONE)));
  end

  // Counter, latched divisor and registered outputs. divQ resets to 1 so the
  // first enabled edge is already a boundary and loads the real divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      divQ    <= ONE;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      divQ    <= clampDiv(div_n);
      clk_out <= 1'b1;
      tick    <= 1'b1;
    end else if (en) begin
      cnt     <= cntInc;
      clk_out <= (cntInc < (divQ >> 1));
      tick    <= 1'b0;
    end else begin
      tick    <= 1'b0;
    end
  end

  assign cur_div = divQ;

endmodule

// File: tb/tb_freq_div.sv
// Self-checking bench for freq_div: a period/position model checked every
// cycle, plus directed sequences with hand-derived tick and clk_out patterns.
module tb_freq_div;
  import freq_div_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [DIV_W-1:0] div_n;
  logic             clk_out;
  logic             tick;
  logic [DIV_W-1:0] cur_div;

  int checks = 0;
  int errors = 0;

  freq_div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .div_n   (div_n),
    .clk_out (clk_out),
    .tick    (tick),
    .cur_div (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a period of length mPer is either not yet started, or at position
  // mPos. Outputs follow directly: high for the first floor(P/2) positions.
  logic             mStarted;
  logic [DIV_W-1:0] mPer;
  logic [DIV_W-1:0] mPos;
  logic             mTick;

  function automatic logic [DIV_W-1:0] effOf(input logic [DIV_W-1:0] d);
    return (d < 2) ? 2 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mStarted <= 1'b0;
      mPer     <= 1;
      mPos     <= 0;
      mTick    <= 1'b0;
    end else if (clr || (en && (!mStarted || mPos == mPer - 1))) begin
      mStarted <= 1'b1;
      mPer     <= effOf(div_n);
      mPos     <= 0;
      mTick    <= 1'b1;
    end else if (en) begin
      mPos     <= mPos + 1;
      mTick    <= 1'b0;
    end else begin
      mTick    <= 1'b0;
    end
  end

  task automatic checkVal(input string name, input logic [DIV_W-1:0] act, input logic [DIV_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process against the model on every falling edge.
  always @(negedge clk) begin
    checkVal("model_tick", {31'd0, tick}, {31'd0, mTick});
    checkVal("model_clk_out", {31'd0, clk_out}, {31'd0, (mStarted && (mPos < (mPer >> 1)))});
    checkVal("model_cur_div", cur_div, mStarted ? mPer : 1);
  end

  // Drive n cycles with fixed inputs; expected bits are given MSB-first in time.
  task automatic runSeq(input string name, input int n, input logic e, input logic c,
                        input logic [DIV_W-1:0] d, input logic [31:0] tExp, input logic [31:0] cExp);
    for (int i = 0; i < n; i++) begin
      en    = e;
      clr   = c;
      div_n = d;
      @(posedge clk);
      @(negedge clk);
      checkVal({name, "_tick"}, {31'd0, tick}, {31'd0, tExp[n-1-i]});
      checkVal({name, "_clk_out"}, {31'd0, clk_out}, {31'd0, cExp[n-1-i]});
    end
  endtask

  int nTicks;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    div_n = '0;
    repeat (2) @(negedge clk);
    checkVal("rst_clk_out", {31'd0, clk_out}, 0);
    checkVal("rst_tick", {31'd0, tick}, 0);
    checkVal("rst_cur_div", cur_div, 1);
    rst_n = 1'b1;

    runSeq("div4", 8, 1, 0, 4, 32'b10001000, 32'b11001100);
    checkVal("div4_cur", cur_div, 4);

    runSeq("div5", 10, 1, 0, 5, 32'b1000010000, 32'b1100011000);
    checkVal("div5_cur", cur_div, 5);

    runSeq("back4", 2, 1, 0, 4, 32'b10, 32'b11);
    runSeq("mid6a", 2, 1, 0, 6, 32'b00, 32'b00);
    checkVal("mid6_old_cur", cur_div, 4);
    runSeq("mid6b", 6, 1, 0, 6, 32'b100000, 32'b111000);
    checkVal("mid6_new_cur", cur_div, 6);

    runSeq("div0", 4, 1, 0, 0, 32'b1010, 32'b1010);
    checkVal("div0_cur", cur_div, 2);
    runSeq("div1", 4, 1, 0, 1, 32'b1010, 32'b1010);
    checkVal("div1_cur", cur_div, 2);

    runSeq("div8a", 3, 1, 0, 8, 32'b100, 32'b111);
    runSeq("freeze", 3, 0, 0, 8, 32'b000, 32'b111);
    runSeq("resume", 3, 1, 0, 8, 32'b000, 32'b100);
    runSeq("clr", 1, 1, 1, 8, 32'b1, 32'b1);
    runSeq("afterClr", 1, 1, 0, 8, 32'b0, 32'b1);
    runSeq("clrHold3", 2, 0, 1, 3, 32'b11, 32'b11);
    checkVal("clrHold3_cur", cur_div, 3);
    runSeq("clrHold9", 1, 1, 1, 9, 32'b1, 32'b1);
    checkVal("clrHold9_cur", cur_div, 9);

    runSeq("maxLoad", 1, 1, 1, '1, 32'b1, 32'b1);
    runSeq("maxRun", 3, 1, 0, '1, 32'b000, 32'b111);
    checkVal("max_cur", cur_div, 32'hFFFF_FFFF);

    #1 rst_n = 1'b0;
    #1;
    checkVal("arst1_cur_div", cur_div, 1);
    checkVal("arst1_clk_out", {31'd0, clk_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    runSeq("sel0", 1, 1, 0, DIV_SEL0, 32'b1, 32'b1);
    checkVal("sel0_cur", cur_div, 512000);

    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    en     = 1'b1;
    clr    = 1'b0;
    div_n  = 20000;
    nTicks = 0;
    repeat (40001) begin
      @(posedge clk);
      @(negedge clk);
      if (tick) nTicks++;
    end
    checkVal("long_ticks", nTicks, 3);
    checkVal("long_last_tick", {31'd0, tick}, 1);
    checkVal("long_last_clk_out", {31'd0, clk_out}, 1);

    #1 rst_n = 1'b0;
    #1;
    checkVal("arst2_tick", {31'd0, tick}, 0);
    checkVal("arst2_clk_out", {31'd0, clk_out}, 0);
    checkVal("arst2_cur_div", cur_div, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
